// File: rtl/bram_sweep_reader.sv
// bram_sweep_reader
// DATA_W x 2^ADDR_W synchronous RAM with a load port. A start request sweeps an address
// window (base_addr .. base_addr+count-1, wrapping modulo DEPTH) and streams each word out on
// a valid/ready interface through a 2-entry show-ahead FIFO, with full backpressure.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data     load port, usable at any time (also during a sweep)
//   start, base_addr, count     sweep request, sampled only while idle
//   busy, done                  busy from accepted start until done; done is a 1-cycle pulse
//   dout, dout_valid, dout_ready, dout_last   output stream, dout_last on the final word
//   checksum                    XOR of all words delivered in the last sweep
//
// Optional feature macro: BRAM_SWEEP_CHECKSUM_EN (checksum logic); undefined -> checksum = 0.

module bram_sweep_reader #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_last,
   output logic [DATA_W-1:0] checksum
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] OneW = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   issued_q;
   logic              setup_q;
   logic              rvld_q;
   logic              rlast_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] f_data0_q, f_data1_q;
   logic              f_last0_q, f_last1_q;
   logic [1:0]        f_cnt_q;
   logic              done_q;

   logic              accept;
   logic              pop;
   logic              rd_en;
   logic              done_d;
   logic              last_issue;
   logic [1:0]        occ;
   logic [ADDR_W-1:0] rd_addr;

   assign accept     = (state_q == StIdle) && start;
   assign pop        = (f_cnt_q != 2'd0) && dout_ready;
   // Words held or owed to the FIFO after this cycle's pop; at most one read is in flight.
   assign occ        = f_cnt_q + {1'b0, rvld_q} - {1'b0, pop};
   assign last_issue = (issued_q == (count_q - OneW));
   assign rd_addr    = base_q + issued_q[ADDR_W-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start && (count != '0)) state_d = StSweep;
         StSweep: if (rd_en && last_issue) state_d = StDrain;
         StDrain: if (pop && f_last0_q) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs. The cycle after acceptance is a setup cycle, so the first read lands on the
   // second edge and its word is visible after the third.
   always_comb begin
      busy   = (state_q != StIdle);
      rd_en  = (state_q == StSweep) && !setup_q && (occ < 2'd2);
      done_d = (accept && (count == '0)) || ((state_q == StDrain) && pop && f_last0_q);
   end

   // Memory: not reset; read-first, so a same-edge write to the read address returns old data.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rdata_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q    <= '0;
         count_q   <= '0;
         issued_q  <= '0;
         setup_q   <= 1'b0;
         rvld_q    <= 1'b0;
         rlast_q   <= 1'b0;
         f_data0_q <= '0;
         f_data1_q <= '0;
         f_last0_q <= 1'b0;
         f_last1_q <= 1'b0;
         f_cnt_q   <= 2'd0;
         done_q    <= 1'b0;
      end else begin
         done_q <= done_d;
         if (accept) begin
            base_q   <= base_addr;
            count_q  <= count;
            issued_q <= '0;
            setup_q  <= 1'b1;
         end else begin
            setup_q <= 1'b0;
            if (rd_en) issued_q <= issued_q + OneW;
         end
         rvld_q <= rd_en;
         if (rd_en) rlast_q <= last_issue;

         // Shift FIFO: entry 0 is the head. The credit rule keeps a push off a full FIFO.
         case ({rvld_q, pop})
            2'b10: begin
               if (f_cnt_q == 2'd0) begin
                  f_data0_q <= rdata_q;
                  f_last0_q <= rlast_q;
               end else begin
                  f_data1_q <= rdata_q;
                  f_last1_q <= rlast_q;
               end
               f_cnt_q <= f_cnt_q + 2'd1;
            end
            2'b01: begin
               f_data0_q <= f_data1_q;
               f_last0_q <= f_last1_q;
               f_cnt_q   <= f_cnt_q - 2'd1;
            end
            2'b11: begin
               if (f_cnt_q == 2'd1) begin
                  f_data0_q <= rdata_q;
                  f_last0_q <= rlast_q;
               end else begin
                  f_data0_q <= f_data1_q;
                  f_last0_q <= f_last1_q;
                  f_data1_q <= rdata_q;
                  f_last1_q <= rlast_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout_valid = (f_cnt_q != 2'd0);
   assign dout       = dout_valid ? f_data0_q : '0;
   assign dout_last  = dout_valid && f_last0_q;
   assign done       = done_q;

`ifdef BRAM_SWEEP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else if (accept) begin
         csum_q <= '0;
      end else if (pop) begin
         csum_q <= csum_q ^ f_data0_q;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_sweep_reader.sv
module tb_bram_sweep_reader;

   localparam int DW = 128;
   localparam int AW = 7;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          busy;
   logic          done;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          dout_last;
   logic [DW-1:0] checksum;

   int n_chk;
   int n_fail;

   logic [DW-1:0] model [128];

   bram_sweep_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .checksum   (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      model[a] = d;
   endtask

   task automatic chk_csum(input string tag, input logic [DW-1:0] exp);
`ifdef BRAM_SWEEP_CHECKSUM_EN
      chk(tag, checksum, exp);
`else
      chk(tag, checksum, '0);
`endif
   endtask

   // One sweep. Iteration e samples just after edge e (edge 0 accepts start).
   // poke_e: re-assert start (ignored) at that iteration; wr_e: write 0xAA to addr 5 there.
   task automatic sweep(input string nm, input logic [AW-1:0] b, input logic [AW:0] n,
                        input bit bp, input int poke_e, input int wr_e);
      logic [DW-1:0] held_d;
      logic [DW-1:0] xs;
      logic          held_l;
      logic [AW-1:0] a;
      logic [15:0]   pat;
      bit            held;
      bit            fin;
      bit            rdy;
      int            idx;
      pat       = 16'b1001_1101_0010_0110;
      base_addr = b;
      count     = n;
      start     = 1'b1;
      tick();
      start  = 1'b0;
      idx    = 0;
      fin    = 1'b0;
      held   = 1'b0;
      held_d = '0;
      held_l = 1'b0;
      xs     = '0;
      chk({nm, "_busy"}, DW'(busy), DW'(1));
      for (int e = 0; e < 300 && !fin; e++) begin
         if (done) begin
            fin = 1'b1;
            if (!bp) chk({nm, "_done_edge"}, DW'(e), DW'(int'(n) + 3));
            chk({nm, "_nwords"}, DW'(idx), DW'(n));
            chk({nm, "_busy_at_done"}, DW'(busy), DW'(0));
            chk({nm, "_valid_at_done"}, DW'(dout_valid), DW'(0));
            chk_csum({nm, "_csum"}, xs);
         end else begin
            if (!bp) chk({nm, "_valid_t"}, DW'(dout_valid), DW'(e >= 3 && e <= int'(n) + 2));
            rdy = bp ? pat[4'(e % 16)] : 1'b1;
            dout_ready = rdy;
            if (dout_valid) begin
               if (held) begin
                  chk({nm, "_stall_data"}, dout, held_d);
                  chk({nm, "_stall_last"}, DW'(dout_last), DW'(held_l));
               end
               if (rdy) begin
                  a = b + AW'(idx);
                  chk({nm, "_data"}, dout, model[a]);
                  chk({nm, "_last"}, DW'(dout_last), DW'(idx == int'(n) - 1));
                  xs   = xs ^ dout;
                  idx++;
                  held = 1'b0;
               end else begin
                  held   = 1'b1;
                  held_d = dout;
                  held_l = dout_last;
               end
            end
            if (e == poke_e) begin
               start     = 1'b1;
               base_addr = b + 7'd9;
               count     = 8'd50;
            end
            if (e == wr_e) begin
               wr_en   = 1'b1;
               wr_addr = 7'd5;
               wr_data = 128'hAA;
            end
            tick();
            start     = 1'b0;
            wr_en     = 1'b0;
            base_addr = b;
            count     = n;
         end
      end
      chk({nm, "_done_seen"}, DW'(fin), DW'(1));
      dout_ready = 1'b1;
      tick();
      chk({nm, "_done_pulse_1cyc"}, DW'(done), DW'(0));
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      start      = 1'b0;
      base_addr  = '0;
      count      = '0;
      dout_ready = 1'b1;
      for (int i = 0; i < 128; i++) model[i] = '0;

      #12;
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_valid", DW'(dout_valid), DW'(0));
      chk("rst_last", DW'(dout_last), DW'(0));
      chk("rst_dout", dout, '0);
      chk("rst_csum", checksum, '0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 128; i++) wr(7'(i), DW'(i + 1));

      // Full sweep, no backpressure: words 1..128; XOR(1..128) = 128.
      sweep("full", 7'd0, 8'd128, 1'b0, -1, -1);
      chk_csum("full_csum_128", 128'd128);

      // Wrap-around: addresses 126, 127, 0, 1 -> words 127, 128, 1, 2.
      sweep("wrap", 7'd126, 8'd4, 1'b0, -1, -1);

      sweep("bp", 7'd40, 8'd16, 1'b1, -1, -1);

      // count = 0: done next cycle, no words.
      base_addr = 7'd10;
      count     = 8'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("cnt0_done", DW'(done), DW'(1));
      chk("cnt0_busy", DW'(busy), DW'(0));
      chk("cnt0_valid", DW'(dout_valid), DW'(0));
      chk_csum("cnt0_csum", '0);
      tick();
      chk("cnt0_done_low", DW'(done), DW'(0));
      chk("cnt0_valid_low", DW'(dout_valid), DW'(0));

      // Start during a 10-word sweep is ignored.
      sweep("busy_start", 7'd60, 8'd10, 1'b0, 2, -1);

      // Reset after 5 of 20 words (handshakes at edges 4..8).
      base_addr = 7'd100;
      count     = 8'd20;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("mid_valid", DW'(dout_valid), DW'(1));
      chk("mid_word6", dout, model[105]);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", DW'(busy), DW'(0));
      chk("arst_done", DW'(done), DW'(0));
      chk("arst_valid", DW'(dout_valid), DW'(0));
      chk("arst_last", DW'(dout_last), DW'(0));
      chk("arst_dout", dout, '0);
      chk("arst_csum", checksum, '0);
      tick();
      tick();
      chk("arst_no_done", DW'(done), DW'(0));
      #3;
      rst_n = 1'b1;
      tick();
      chk("post_rst_no_done", DW'(done), DW'(0));
      chk("post_rst_valid", DW'(dout_valid), DW'(0));
      sweep("post_rst", 7'd20, 8'd20, 1'b0, -1, -1);

      // Read-during-write: base 3, index 2 (addr 5) is read on edge 4, same edge as the write.
      sweep("rdw_old", 7'd3, 8'd6, 1'b0, -1, 3);
      model[5] = 128'hAA;
      sweep("rdw_new", 7'd5, 8'd1, 1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
